// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_fifo_ctrl
// Brief    : Reset/enable sequencer and access guard for a BRAM-based
//            synchronous FIFO macro (FIFO_SYNC_MACRO). Drives the macro's
//            RST/WREN/RDEN pins and runs the reset pulse-width/recovery
//            sequence after power-up and on every flush. Refuses
//            write-when-full and read-when-empty. Tracks its own occupancy
//            and keeps sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH       : entries in the macro
//   RST_CYCLES  : cycles fifo_rst_o is held high per reset sequence (>= 1)
//   WAIT_CYCLES : cycles after fifo_rst_o falls before enables may rise (>= 1)
//   CNT_W       : derived width of usage_o (not meant to be overridden)
// Ports
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   flush_i      in   synchronous request to empty the FIFO (full reset seq)
//   push_i       in   producer write request
//   pop_i        in   consumer read request
//   ready_o      out  sequencer is in READY; accesses are legal
//   full_o       out  FIFO cannot accept a write (forced high outside READY)
//   empty_o      out  FIFO holds no data (forced high outside READY)
//   usage_o      out  current occupancy, 0..DEPTH
//   overflow_o   out  sticky: a push was refused while READY
//   underflow_o  out  sticky: a pop was refused while READY
//   fifo_rst_o   out  macro RST
//   fifo_wren_o  out  macro WREN
//   fifo_rden_o  out  macro RDEN
// ============================================================================
module sram_fifo_ctrl #(
  parameter int DEPTH       = 512,
  parameter int RST_CYCLES  = 5,
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic             ready_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] usage_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             fifo_rst_o,
  output logic             fifo_wren_o,
  output logic             fifo_rden_o
);

  // Sequencer cycle counter must hold the larger of the two phase lengths.
  localparam int CYC_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0] RST_LAST  = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] WAIT_LAST = CYC_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] USAGE_MAX = CNT_W'(DEPTH);

  localparam logic [1:0] ST_RST_ASSERT = 2'd0;
  localparam logic [1:0] ST_RST_WAIT   = 2'd1;
  localparam logic [1:0] ST_READY      = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CYC_W-1:0] cyc;
  logic [CYC_W-1:0] cyc_next;
  logic [CNT_W-1:0] usage_q;
  logic [CNT_W-1:0] usage_next;
  logic             overflow_q;
  logic             underflow_q;

  logic             ready;
  logic             at_full;
  logic             at_empty;
  logic             wr_ok;
  logic             rd_ok;
  logic             ovf_hit;
  logic             unf_hit;

  // --------------------------------------------------------------------------
  // Access guard
  // --------------------------------------------------------------------------
  assign ready    = (state == ST_READY);
  assign at_full  = (usage_q == USAGE_MAX);
  assign at_empty = (usage_q == '0);

  // Outside READY both sides see full/empty so producer and consumer stall.
  assign full_o  = ~ready | at_full;
  assign empty_o = ~ready | at_empty;

  // Flush wins over a same-cycle access: the macro is about to be reset, so
  // nothing may be written to or read from it on that edge.
  assign wr_ok = ready & push_i & ~at_full  & ~flush_i;
  assign rd_ok = ready & pop_i  & ~at_empty & ~flush_i;

  // Refused requests only count as errors while the FIFO is usable; requests
  // made during the reset sequence are silently ignored.
  assign ovf_hit = ready & push_i & at_full  & ~flush_i;
  assign unf_hit = ready & pop_i  & at_empty & ~flush_i;

  // --------------------------------------------------------------------------
  // Reset sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cyc_next   = cyc;
    if (flush_i) begin
      state_next = ST_RST_ASSERT;
      cyc_next   = '0;
    end else begin
      case (state)
        ST_RST_ASSERT: begin
          if (cyc == RST_LAST) begin
            state_next = ST_RST_WAIT;
            cyc_next   = '0;
          end else begin
            cyc_next = cyc + 1'b1;
          end
        end
        ST_RST_WAIT: begin
          if (cyc == WAIT_LAST) begin
            state_next = ST_READY;
            cyc_next   = '0;
          end else begin
            cyc_next = cyc + 1'b1;
          end
        end
        ST_READY: begin
          cyc_next = '0;
        end
        default: begin
          // Unreachable encoding: re-run a full reset sequence to recover.
          state_next = ST_RST_ASSERT;
          cyc_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_RST_ASSERT;
      cyc   <= '0;
    end else begin
      state <= state_next;
      cyc   <= cyc_next;
    end
  end

  // --------------------------------------------------------------------------
  // Occupancy and sticky flags
  // --------------------------------------------------------------------------
  // A simultaneous accepted write and read cancel out; the guards above keep
  // usage within 0..DEPTH so no saturation is needed here.
  always_comb begin
    usage_next = usage_q;
    case ({wr_ok, rd_ok})
      2'b10:   usage_next = usage_q + 1'b1;
      2'b01:   usage_next = usage_q - 1'b1;
      default: usage_next = usage_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      usage_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush_i) begin
      usage_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      usage_q <= usage_next;
      if (ovf_hit) begin
        overflow_q <= 1'b1;
      end
      if (unf_hit) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ready_o     = ready;
  assign usage_o     = usage_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
  assign fifo_rst_o  = (state == ST_RST_ASSERT);
  assign fifo_wren_o = wr_ok;
  assign fifo_rden_o = rd_ok;

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_fifo_ctrl
// Brief    : Self-checking bench for sram_fifo_ctrl. A behavioural model tracks
//            "edges since reset/flush", occupancy and the sticky flags; each
//            scenario task drives stimulus and compares DUT outputs inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_fifo_ctrl;

  localparam int DEPTH = 512;
  localparam int RSTC  = 5;
  localparam int WAITC = 4;
  localparam int SEQ   = RSTC + WAITC;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             push  = 1'b0;
  logic             pop   = 1'b0;
  logic             ready_o;
  logic             full_o;
  logic             empty_o;
  logic [CNT_W-1:0] usage_o;
  logic             overflow_o;
  logic             underflow_o;
  logic             fifo_rst_o;
  logic             fifo_wren_o;
  logic             fifo_rden_o;

  sram_fifo_ctrl #(
    .DEPTH       (DEPTH),
    .RST_CYCLES  (RSTC),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .pop_i       (pop),
    .ready_o     (ready_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .usage_o     (usage_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o),
    .fifo_rst_o  (fifo_rst_o),
    .fifo_wren_o (fifo_wren_o),
    .fifo_rden_o (fifo_rden_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: edges elapsed since reset release / flush, occupancy,
  // sticky flags.
  int since  = 0;
  int musage = 0;
  bit movf   = 1'b0;
  bit munf   = 1'b0;

  bit obs_wren, obs_rden, exp_wren, exp_rden;

  function automatic bit m_ready();
    return since >= SEQ;
  endfunction

  // One clock cycle: drive at the falling edge, capture the combinational
  // enables before the rising edge, then advance the model past the edge.
  task automatic cycle(input bit p, input bit q, input bit f);
    bit rdy;
    @(negedge clk);
    push  = p;
    pop   = q;
    flush = f;
    #1;
    obs_wren = fifo_wren_o;
    obs_rden = fifo_rden_o;
    rdy      = m_ready();
    exp_wren = rdy && p && (musage < DEPTH) && !f;
    exp_rden = rdy && q && (musage > 0) && !f;
    @(posedge clk);
    if (f) begin
      since  = 0;
      musage = 0;
      movf   = 1'b0;
      munf   = 1'b0;
    end else begin
      if (rdy && p && musage == DEPTH) movf = 1'b1;
      if (rdy && q && musage == 0)     munf = 1'b1;
      musage = musage + int'(exp_wren) - int'(exp_rden);
      if (since < SEQ) since++;
    end
    #1;
  endtask

  task automatic reinit();
    cycle(1'b0, 1'b0, 1'b1);
    repeat (SEQ) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (fifo_rst_o !== 1'b1) begin errors++; $display("FAIL reset_fifo_rst: got %b exp 1", fifo_rst_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready_o); end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL reset_full: got %b exp 1", full_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", empty_o); end
    checks++; if (usage_o !== '0) begin errors++; $display("FAIL reset_usage: got %0d exp 0", usage_o); end
    checks++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b exp 00", overflow_o, underflow_o); end
    checks++; if (fifo_wren_o !== 1'b0 || fifo_rden_o !== 1'b0) begin errors++; $display("FAIL reset_enables: got %b%b exp 00", fifo_wren_o, fifo_rden_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    since = 0;
    for (int k = 1; k <= SEQ; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++; if (fifo_rst_o !== (k < RSTC)) begin errors++; $display("FAIL powerup_fifo_rst edge %0d: got %b exp %b", k, fifo_rst_o, (k < RSTC)); end
      checks++; if (ready_o !== (k >= SEQ)) begin errors++; $display("FAIL powerup_ready edge %0d: got %b exp %b", k, ready_o, (k >= SEQ)); end
    end
    checks++; if (usage_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("FAIL powerup_state: usage %0d empty %b full %b exp 0 1 0", usage_o, empty_o, full_o); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++; if (obs_wren !== 1'b1 || usage_o !== CNT_W'(i)) begin errors++; $display("FAIL fill %0d: wren %b usage %0d exp 1 %0d", i, obs_wren, usage_o, i); end
    end
    checks++; if (full_o !== 1'b1 || empty_o !== 1'b0) begin errors++; $display("FAIL fill_full: full %b empty %b exp 1 0", full_o, empty_o); end
    cycle(1'b1, 1'b0, 1'b0);
    checks++; if (obs_wren !== 1'b0) begin errors++; $display("FAIL push_when_full_wren: got %b exp 0", obs_wren); end
    checks++; if (overflow_o !== 1'b1 || usage_o !== CNT_W'(DEPTH)) begin errors++; $display("FAIL overflow: flag %b usage %0d exp 1 %0d", overflow_o, usage_o, DEPTH); end
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      checks++; if (obs_rden !== 1'b1 || usage_o !== CNT_W'(DEPTH - i)) begin errors++; $display("FAIL drain %0d: rden %b usage %0d exp 1 %0d", i, obs_rden, usage_o, DEPTH - i); end
    end
    checks++; if (empty_o !== 1'b1 || underflow_o !== 1'b0) begin errors++; $display("FAIL drain_empty: empty %b underflow %b exp 1 0", empty_o, underflow_o); end
    cycle(1'b0, 1'b1, 1'b0);
    checks++; if (obs_rden !== 1'b0 || underflow_o !== 1'b1) begin errors++; $display("FAIL underflow: rden %b flag %b exp 0 1", obs_rden, underflow_o); end
  endtask

  task automatic test_simultaneous();
    reinit();
    cycle(1'b1, 1'b1, 1'b0);
    checks++; if (obs_wren !== 1'b1 || obs_rden !== 1'b0 || usage_o !== CNT_W'(1)) begin errors++; $display("FAIL simul_empty: wren %b rden %b usage %0d exp 1 0 1", obs_wren, obs_rden, usage_o); end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    checks++; if (obs_wren !== 1'b1 || obs_rden !== 1'b1 || usage_o !== CNT_W'(3)) begin errors++; $display("FAIL simul_mid: wren %b rden %b usage %0d exp 1 1 3", obs_wren, obs_rden, usage_o); end
    repeat (DEPTH - 3) cycle(1'b1, 1'b0, 1'b0);
    checks++; if (usage_o !== CNT_W'(DEPTH) || overflow_o !== 1'b0) begin errors++; $display("FAIL simul_fill: usage %0d ovf %b exp %0d 0", usage_o, overflow_o, DEPTH); end
    cycle(1'b1, 1'b1, 1'b0);
    checks++; if (obs_wren !== 1'b0 || obs_rden !== 1'b1 || usage_o !== CNT_W'(DEPTH - 1) || overflow_o !== 1'b1) begin errors++; $display("FAIL simul_full: wren %b rden %b usage %0d ovf %b exp 0 1 %0d 1", obs_wren, obs_rden, usage_o, overflow_o, DEPTH - 1); end
  endtask

  task automatic test_flush_mid();
    reinit();
    cycle(1'b0, 1'b1, 1'b0);
    repeat (DEPTH) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (DEPTH - 100) cycle(1'b0, 1'b1, 1'b0);
    checks++; if (usage_o !== CNT_W'(100) || overflow_o !== 1'b1 || underflow_o !== 1'b1) begin errors++; $display("FAIL flush_setup: usage %0d ovf %b unf %b exp 100 1 1", usage_o, overflow_o, underflow_o); end
    cycle(1'b1, 1'b0, 1'b1);
    checks++; if (obs_wren !== 1'b0) begin errors++; $display("FAIL flush_wren: got %b exp 0", obs_wren); end
    checks++; if (usage_o !== '0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin errors++; $display("FAIL flush_clear: usage %0d ovf %b unf %b exp 0 0 0", usage_o, overflow_o, underflow_o); end
    checks++; if (ready_o !== 1'b0 || fifo_rst_o !== 1'b1) begin errors++; $display("FAIL flush_seq_start: ready %b rst %b exp 0 1", ready_o, fifo_rst_o); end
    for (int k = 1; k <= SEQ; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++; if (fifo_rst_o !== (k < RSTC) || ready_o !== (k >= SEQ)) begin errors++; $display("FAIL flush_seq edge %0d: rst %b ready %b exp %b %b", k, fifo_rst_o, ready_o, (k < RSTC), (k >= SEQ)); end
    end
  endtask

  task automatic test_init_requests();
    cycle(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= SEQ; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++; if (obs_wren !== 1'b0 || obs_rden !== 1'b0 || usage_o !== '0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
        errors++; $display("FAIL init_requests edge %0d: wren %b rden %b usage %0d ovf %b unf %b exp 0 0 0 0 0", k, obs_wren, obs_rden, usage_o, overflow_o, underflow_o);
      end
    end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL init_requests_ready: got %b exp 1", ready_o); end
  endtask

  task automatic test_random();
    bit p, q, f;
    bit efull, eempty;
    reinit();
    for (int ph = 0; ph < 6; ph++) begin
      for (int n = 0; n < 600; n++) begin
        if (ph % 2 == 0) p = ($urandom_range(0, 9) < 8);
        else             p = ($urandom_range(0, 9) < 2);
        q = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 2 : 8));
        f = ($urandom_range(0, 399) == 0);
        cycle(p, q, f);
        efull  = !m_ready() || (musage == DEPTH);
        eempty = !m_ready() || (musage == 0);
        checks++; if (obs_wren !== exp_wren || obs_rden !== exp_rden) begin errors++; $display("FAIL rand_enables: got %b%b exp %b%b", obs_wren, obs_rden, exp_wren, exp_rden); end
        checks++; if (usage_o !== CNT_W'(musage)) begin errors++; $display("FAIL rand_usage: got %0d exp %0d", usage_o, musage); end
        checks++; if (full_o !== efull || empty_o !== eempty || ready_o !== m_ready()) begin errors++; $display("FAIL rand_status: full %b empty %b ready %b exp %b %b %b", full_o, empty_o, ready_o, efull, eempty, m_ready()); end
        checks++; if (overflow_o !== movf || underflow_o !== munf || fifo_rst_o !== (since < RSTC)) begin errors++; $display("FAIL rand_flags: ovf %b unf %b rst %b exp %b %b %b", overflow_o, underflow_o, fifo_rst_o, movf, munf, (since < RSTC)); end
      end
    end
  endtask

  task automatic test_async_reset();
    reinit();
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    push = 1'b1;
    pop  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (usage_o !== '0 || ready_o !== 1'b0 || fifo_rst_o !== 1'b1) begin errors++; $display("FAIL async_state: usage %0d ready %b rst %b exp 0 0 1", usage_o, ready_o, fifo_rst_o); end
    checks++; if (full_o !== 1'b1 || empty_o !== 1'b1) begin errors++; $display("FAIL async_status: full %b empty %b exp 1 1", full_o, empty_o); end
    checks++; if (fifo_wren_o !== 1'b0 || fifo_rden_o !== 1'b0 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin errors++; $display("FAIL async_outputs: wren %b rden %b ovf %b unf %b exp 0 0 0 0", fifo_wren_o, fifo_rden_o, overflow_o, underflow_o); end
    since  = 0;
    musage = 0;
    movf   = 1'b0;
    munf   = 1'b0;
    @(posedge clk); #1;
    push  = 1'b0;
    pop   = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= SEQ; k++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++; if (fifo_rst_o !== (k < RSTC) || ready_o !== (k >= SEQ)) begin errors++; $display("FAIL async_restart edge %0d: rst %b ready %b exp %b %b", k, fifo_rst_o, ready_o, (k < RSTC), (k >= SEQ)); end
    end
    cycle(1'b1, 1'b0, 1'b0);
    checks++; if (obs_wren !== 1'b1 || usage_o !== CNT_W'(1)) begin errors++; $display("FAIL async_resume: wren %b usage %0d exp 1 1", obs_wren, usage_o); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_flush_mid();
    test_init_requests();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
